// File: rtl/pakin.sv
// pakin: packet receiver. Debounces a 4-phase packet channel, reassembles
// TOT_PKS narrow packets (MSB first) into one message, queues completed
// messages in an FSZ-deep FIFO and forwards them on a 4-phase message channel.
// Ports:
//   gch_clk, gch_reset     clock, synchronous active-high reset
//   gch_ready              block initialised and operating
//   rcv0_pakio, rcv0_req   incoming packet payload and request
//   rcv0_ack_out           packet acknowledge
//   snd0_msg, snd0_req_out outgoing message and request
//   snd0_ack               message acknowledge from consumer

module pakin_dbnc #(
    parameter int CKS = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_ckd
);
    localparam int CW = $clog2(CKS + 1);

    logic          r_prev;
    logic [CW-1:0] r_run;
    logic [CW-1:0] w_run;

    // Length of the current run of equal samples, including this one,
    // saturating at CKS.
    always_comb begin
        w_run = CW'(1);
        if (i_raw == r_prev) begin
            if (r_run == CW'(CKS)) begin
                w_run = r_run;
            end else begin
                w_run = r_run + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            r_run  <= '0;
            o_ckd  <= 1'b0;
        end else begin
            r_prev <= i_raw;
            r_run  <= w_run;
            if (w_run == CW'(CKS)) begin
                o_ckd <= i_raw;
            end
        end
    end
endmodule

module pakin #(
    parameter int PSZ         = 4,
    parameter int FSZ         = 4,
    parameter int ASZ         = 4,
    parameter int DSZ         = 4,
    parameter int RSZ         = 4,
    parameter int RCV_REQ_CKS = 2,
    parameter int SND_ACK_CKS = 2
) (
    input  logic                       gch_clk,
    input  logic                       gch_reset,
    output logic                       gch_ready,
    input  logic [PSZ-1:0]             rcv0_pakio,
    input  logic                       rcv0_req,
    output logic                       rcv0_ack_out,
    output logic [2*ASZ+DSZ+RSZ-1:0]   snd0_msg,
    output logic                       snd0_req_out,
    input  logic                       snd0_ack
);
    localparam int MSZ     = 2*ASZ + DSZ + RSZ;
    localparam int TOT_PKS = (MSZ + PSZ - 1) / PSZ;
    localparam int REM     = MSZ - (TOT_PKS - 1) * PSZ;
    localparam int AW      = TOT_PKS * PSZ;
    localparam int PW      = $clog2(FSZ);
    localparam int KW      = (TOT_PKS > 1) ? $clog2(TOT_PKS) : 1;

    logic           w_ckd_req;
    logic           w_ckd_ack;
    logic           r_ready;
    logic           r_ack;
    logic           r_req;
    logic [MSZ-1:0] r_msg;
    logic [AW-1:0]  r_asm;
    logic [KW-1:0]  r_pk;
    logic [MSZ-1:0] r_mem [FSZ];
    logic [PW-1:0]  r_wp;
    logic [PW-1:0]  r_rp;
    logic [PW:0]    r_cnt;

    logic           w_full;
    logic           w_empty;
    logic           w_last;
    logic           w_pop;
    logic           w_cap;
    logic           w_push;
    logic           w_load;
    logic [AW-1:0]  w_shift;
    logic [MSZ-1:0] w_asm_msg;

    pakin_dbnc #(.CKS(RCV_REQ_CKS)) u_dbnc_req (
        .i_clk (gch_clk),
        .i_rst (gch_reset),
        .i_raw (rcv0_req),
        .o_ckd (w_ckd_req)
    );

    pakin_dbnc #(.CKS(SND_ACK_CKS)) u_dbnc_ack (
        .i_clk (gch_clk),
        .i_rst (gch_reset),
        .i_raw (snd0_ack),
        .o_ckd (w_ckd_ack)
    );

    assign w_full  = (r_cnt == (PW+1)'(FSZ));
    assign w_empty = (r_cnt == '0);
    assign w_last  = (r_pk == KW'(TOT_PKS - 1));
    assign w_pop   = !gch_reset && r_ready && r_req && w_ckd_ack;

    // The last packet waits for a free slot; a same-cycle pop frees one.
    assign w_cap   = !gch_reset && r_ready && w_ckd_req && !r_ack
                   && (!w_last || !w_full || w_pop);
    assign w_push  = w_cap && w_last;
    assign w_load  = r_ready && !w_empty && !r_req && !w_ckd_ack;

    // The upper TOT_PKS-1 packet slots of the shifted value are the earlier
    // packets; only the low REM bits of the final packet are kept.
    assign w_shift   = {r_asm[AW-PSZ-1:0], rcv0_pakio};
    assign w_asm_msg = {w_shift[AW-1:PSZ], rcv0_pakio[REM-1:0]};

    always_ff @(posedge gch_clk) begin
        if (w_push) begin
            r_mem[r_wp] <= w_asm_msg;
        end
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            r_ready <= 1'b0;
            r_ack   <= 1'b0;
            r_req   <= 1'b0;
            r_msg   <= '0;
            r_asm   <= '0;
            r_pk    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else if (!r_ready) begin
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_req   <= 1'b0;
            r_asm   <= '0;
            r_pk    <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_cap) begin
                r_asm <= w_shift;
                r_ack <= 1'b1;
                r_pk  <= w_last ? '0 : r_pk + KW'(1);
            end else if (!w_ckd_req && r_ack) begin
                r_ack <= 1'b0;
            end

            if (w_push) begin
                r_wp <= r_wp + PW'(1);
            end

            if (w_pop) begin
                r_rp  <= r_rp + PW'(1);
                r_req <= 1'b0;
            end else if (w_load) begin
                r_msg <= r_mem[r_rp];
                r_req <= 1'b1;
            end

            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - (PW+1)'(1);
            end
        end
    end

    assign gch_ready    = r_ready;
    assign rcv0_ack_out = r_ack;
    assign snd0_req_out = r_req;
    assign snd0_msg     = r_msg;
endmodule

// File: tb/tb_pakin.sv
// tb_pakin: randomized scoreboard bench for pakin. A driver sends messages
// as packets; a monitor/consumer checks each delivered message in order.

module tb_pakin;
    localparam int PSZ = 4;
    localparam int MSZ = 16;
    localparam int TOT = 4;
    localparam int RCK = 2;
    localparam int ACK = 2;

    logic           clk = 1'b0;
    logic           gch_reset;
    logic           gch_ready;
    logic [PSZ-1:0] rcv0_pakio;
    logic           rcv0_req;
    logic           rcv0_ack_out;
    logic [MSZ-1:0] snd0_msg;
    logic           snd0_req_out;
    logic           snd0_ack;

    int             checks = 0;
    int             errors = 0;
    logic [MSZ-1:0] exp_q [$];
    bit             hold_ack = 1'b0;
    int             ack_dly_max = 0;
    time            t_req_rise = 0;
    time            t_req_fall = 0;

    always #5 clk = ~clk;

    pakin #(
        .PSZ(4), .FSZ(4), .ASZ(4), .DSZ(4), .RSZ(4),
        .RCV_REQ_CKS(RCK), .SND_ACK_CKS(ACK)
    ) dut (
        .gch_clk      (clk),
        .gch_reset    (gch_reset),
        .gch_ready    (gch_ready),
        .rcv0_pakio   (rcv0_pakio),
        .rcv0_req     (rcv0_req),
        .rcv0_ack_out (rcv0_ack_out),
        .snd0_msg     (snd0_msg),
        .snd0_req_out (snd0_req_out),
        .snd0_ack     (snd0_ack)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [PSZ-1:0] pkt_of(input logic [MSZ-1:0] m,
                                              input int i);
        logic [MSZ-1:0] s;
        s = m >> (MSZ - (i + 1) * PSZ);
        return s[PSZ-1:0];
    endfunction

    task automatic send_pkt(input logic [PSZ-1:0] p, input int limit,
                            output int lat, output time t_ack);
        int n;
        rcv0_pakio = p;
        rcv0_req = 1'b1;
        lat = 0;
        while (!rcv0_ack_out && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        t_ack = $time;
        if (!rcv0_ack_out) begin
            checks++;
            errors++;
            $display("FAIL pkt_ack_timeout actual=0 required=1");
        end
        rcv0_req = 1'b0;
        n = 0;
        while (rcv0_ack_out && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (rcv0_ack_out) begin
            checks++;
            errors++;
            $display("FAIL pkt_ack_fall_timeout actual=1 required=0");
        end
    endtask

    task automatic send_msg(input logic [MSZ-1:0] m, input int gap,
                            output int lat0, output time t_last);
        int lat;
        exp_q.push_back(m);
        for (int i = 0; i < TOT; i++) begin
            send_pkt(pkt_of(m, i), 400, lat, t_last);
            if (i == 0) lat0 = lat;
            repeat ($urandom_range(0, gap)) @(negedge clk);
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || snd0_req_out || snd0_ack)
               && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || snd0_req_out) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0",
                     exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor and consumer: checks each presented message against the
    // scoreboard head, then acknowledges after a random delay.
    initial begin : consumer
        logic [MSZ-1:0] e;
        int n;
        snd0_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (snd0_req_out) begin
                t_req_rise = $time;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_msg actual=%0h required=none",
                             snd0_msg);
                end else begin
                    e = exp_q.pop_front();
                    chk("msg_value", 32'(snd0_msg), 32'(e));
                end
                while (hold_ack) @(negedge clk);
                repeat ($urandom_range(0, ack_dly_max)) @(negedge clk);
                chk("msg_held", 32'(snd0_msg), 32'(e));
                snd0_ack = 1'b1;
                n = 0;
                while (snd0_req_out && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                t_req_fall = $time;
                chk("ack_to_req_fall", n, ACK + 1);
                snd0_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int n;
        bit seen;
        time t_ack;
        logic [MSZ-1:0] m;

        gch_reset = 1'b1;
        rcv0_req = 1'b0;
        rcv0_pakio = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(rcv0_ack_out), 0);
        chk("rst_req", 32'(snd0_req_out), 0);
        chk("rst_msg", 32'(snd0_msg), 0);
        chk("rst_ready", 32'(gch_ready), 0);
        gch_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(gch_ready), 1);

        // Single message with latency checks.
        send_msg(16'hABCD, 0, lat, t_ack);
        chk("req_to_ack_lat", lat, RCK + 1);
        drain(200);
        n = int'((t_req_rise - t_ack) / 10);
        chk("last_ack_to_req", 32'(n >= 1 && n <= 2), 1);

        // One-cycle glitch must not be captured.
        rcv0_req = 1'b1;
        rcv0_pakio = 4'hF;
        @(negedge clk);
        rcv0_req = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rcv0_ack_out) seen = 1'b1;
        end
        chk("glitch_no_ack", 32'(seen), 0);
        send_msg(16'h5A3C, 2, lat, t_ack);
        drain(300);

        // Backpressure: four buffered, fifth stalls on its last packet,
        // then push and pop land on the same edge.
        hold_ack = 1'b1;
        ack_dly_max = 0;
        for (int k = 1; k <= 4; k++) begin
            m = 16'h1111 * 16'(k);
            send_msg(m, 0, lat, t_ack);
        end
        exp_q.push_back(16'h5555);
        for (int i = 0; i < TOT - 1; i++) begin
            send_pkt(4'h5, 400, lat, t_ack);
        end
        rcv0_pakio = 4'h5;
        rcv0_req = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rcv0_ack_out) seen = 1'b1;
        end
        chk("full_stall_ack", 32'(seen), 0);
        hold_ack = 1'b0;
        n = 0;
        while (!rcv0_ack_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        t_ack = $time;
        chk("stall_release_ack", 32'(rcv0_ack_out), 1);
        @(negedge clk);
        chk("push_pop_same_edge", 32'(t_ack == t_req_fall), 1);
        rcv0_req = 1'b0;
        n = 0;
        while (rcv0_ack_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        drain(2000);

        // Reset in the middle of a message.
        send_pkt(4'h9, 400, lat, t_ack);
        rcv0_pakio = 4'h8;
        rcv0_req = 1'b1;
        n = 0;
        while (!rcv0_ack_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        rcv0_req = 1'b0;
        gch_reset = 1'b1;
        @(negedge clk);
        chk("midrst_ack", 32'(rcv0_ack_out), 0);
        chk("midrst_req", 32'(snd0_req_out), 0);
        chk("midrst_msg", 32'(snd0_msg), 0);
        chk("midrst_ready", 32'(gch_ready), 0);
        gch_reset = 1'b0;
        @(negedge clk);
        send_msg(16'h1234, 0, lat, t_ack);
        drain(300);

        // Wrap-around with random data, gaps and ack delays.
        ack_dly_max = 8;
        for (int k = 0; k < 10; k++) begin
            m = 16'($urandom);
            send_msg(m, 3, lat, t_ack);
        end
        drain(5000);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
